// File: rtl/mutex_pkg.sv
// Shared constants for the mutex value arbiter: FSM encodings and default sizing.
package mutex_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int WR_NUM_DEF = 4;
   localparam int RD_NUM_DEF = 2;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BCAST = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester after last_grant.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  grant
);

   localparam logic [N-1:0] LSB = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] mask;
   logic [N-1:0] hi_req;
   logic [N-1:0] hi_pick;
   logic [N-1:0] lo_pick;

   // Requesters strictly above last_grant get first pick; otherwise wrap to the lowest index.
   assign mask    = ({N{1'b1}} << last_grant) << 1;
   assign hi_req  = req & mask;
   assign hi_pick = hi_req & (~hi_req + LSB);
   assign lo_pick = req & (~req + LSB);
   assign grant   = (hi_req != '0) ? hi_pick : lo_pick;

endmodule

// File: rtl/mutex_value_arbiter.sv
// Arbitrates writers onto one shared value and broadcasts changes to every reader.
// state | meaning
// IDLE  | accepting one write per cycle via round-robin grant
// BCAST | value changed; waiting for every reader to acknowledge
module mutex_value_arbiter
   import mutex_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int WR_NUM = WR_NUM_DEF,
   parameter int RD_NUM = RD_NUM_DEF
) (
   input  logic                     core_clk,
   input  logic                     core_rst,
   input  logic [WIDTH*WR_NUM-1:0]  wr_value_i,
   input  logic [WR_NUM-1:0]        wr_valid_i,
   output logic [WR_NUM-1:0]        wr_ready_o,
   output logic [RD_NUM-1:0]        rd_valid_o,
   input  logic [RD_NUM-1:0]        rd_ready_i,
   output logic [RD_NUM*WIDTH-1:0]  rd_value_o,
   output logic                     busy_o
);

   localparam int IW = (WR_NUM > 1) ? $clog2(WR_NUM) : 1;

   logic [0:0]        state;
   logic [WIDTH-1:0]  cur_val;
   logic [WIDTH-1:0]  sel_val;
   logic [RD_NUM-1:0] rd_valid;
   logic [RD_NUM-1:0] rd_valid_nxt;
   logic [IW-1:0]     last_grant;
   logic [IW-1:0]     grant_idx;
   logic [WR_NUM-1:0] grant;
   logic              hs;

   rr_arbiter #(
      .N  (WR_NUM),
      .IW (IW)
   ) u_rr (
      .req        (wr_valid_i),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign wr_ready_o = (state == ST_IDLE && !core_rst) ? grant : '0;

   always_comb begin
      sel_val   = '0;
      grant_idx = '0;
      for (int k = 0; k < WR_NUM; k++) begin
         if (wr_ready_o[k]) begin
            sel_val   = wr_value_i[k*WIDTH +: WIDTH];
            grant_idx = IW'(k);
         end
      end
   end

   assign hs           = |(wr_valid_i & wr_ready_o);
   assign rd_valid_nxt = rd_valid & ~rd_ready_i;

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         state      <= ST_IDLE;
         cur_val    <= '0;
         rd_valid   <= '0;
         last_grant <= IW'(WR_NUM - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (hs) begin
                  last_grant <= grant_idx;
                  // Rewriting the same value is accepted silently; readers see no change.
                  if (sel_val != cur_val) begin
                     cur_val  <= sel_val;
                     rd_valid <= '1;
                     state    <= ST_BCAST;
                  end
               end
            end
            default: begin
               rd_valid <= rd_valid_nxt;
               if (rd_valid_nxt == '0) state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o     = (state == ST_BCAST);
   assign rd_valid_o = rd_valid;
   assign rd_value_o = {RD_NUM{cur_val}};

endmodule

// File: tb/tb_mutex_value_arbiter.sv
// Directed bench for mutex_value_arbiter with a scoreboard queue of expected observations.
module tb_mutex_value_arbiter;

   localparam int W  = 32;
   localparam int WN = 4;
   localparam int RN = 2;

   logic            core_clk;
   logic            core_rst;
   logic [W*WN-1:0] wr_value;
   logic [WN-1:0]   wr_valid;
   logic [WN-1:0]   wr_ready_o;
   logic [RN-1:0]   rd_valid_o;
   logic [RN-1:0]   rd_ready;
   logic [RN*W-1:0] rd_value_o;
   logic            busy_o;

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] exp_q[$];

   mutex_value_arbiter #(
      .WIDTH  (W),
      .WR_NUM (WN),
      .RD_NUM (RN)
   ) dut (
      .core_clk   (core_clk),
      .core_rst   (core_rst),
      .wr_value_i (wr_value),
      .wr_valid_i (wr_valid),
      .wr_ready_o (wr_ready_o),
      .rd_valid_o (rd_valid_o),
      .rd_ready_i (rd_ready),
      .rd_value_o (rd_value_o),
      .busy_o     (busy_o)
   );

   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   task automatic chk(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic look(input string tag, input logic [3:0] e_wrr,
                       input logic [1:0] e_rdv, input logic e_busy);
      exp_q.push_back(64'(e_wrr));
      exp_q.push_back(64'(e_rdv));
      exp_q.push_back(64'(e_busy));
      #1;
      chk({tag, ".wr_ready"}, 64'(wr_ready_o));
      chk({tag, ".rd_valid"}, 64'(rd_valid_o));
      chk({tag, ".busy"},     64'(busy_o));
   endtask

   task automatic look_val(input string tag, input logic [31:0] e);
      exp_q.push_back(64'(e));
      exp_q.push_back(64'(e));
      #1;
      chk({tag, ".rd_value0"}, 64'(rd_value_o[0 +: W]));
      chk({tag, ".rd_value1"}, 64'(rd_value_o[W +: W]));
   endtask

   task automatic set_val(input int k, input logic [31:0] v);
      wr_value[k*W +: W] = v;
   endtask

   task automatic nxt();
      @(negedge core_clk);
   endtask

   initial begin
      core_rst = 1'b1;
      wr_valid = '0;
      rd_ready = '0;
      wr_value = '0;

      // Reset: outputs quiet even with every writer requesting
      nxt(); wr_valid = 4'hF;
      look("rst", 4'b0000, 2'b00, 1'b0);
      look_val("rst", 32'h0);

      // Four writers all requesting: grants 0,1,2,3 each followed by BCAST
      for (int k = 0; k < 4; k++) set_val(k, 32'h11 * (k + 1));
      rd_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         nxt(); if (k == 0) core_rst = 1'b0;
         look($sformatf("rr_grant%0d", k), 4'(1 << k), 2'b00, 1'b0);
         nxt(); if (k == 3) wr_valid = '0;
         look($sformatf("rr_bcast%0d", k), 4'b0000, 2'b11, 1'b1);
         look_val($sformatf("rr_val%0d", k), 32'h11 * (k + 1));
      end
      nxt(); rd_ready = '0;
      look("rr_idle", 4'b0000, 2'b00, 1'b0);

      // Writer 2 writes 0xA5; readers ack at different times
      nxt(); set_val(2, 32'hA5); wr_valid = 4'b0100;
      look("stag_grant", 4'b0100, 2'b00, 1'b0);
      nxt(); wr_valid = 4'b1000; rd_ready = 2'b01;
      look("stag_t1", 4'b0000, 2'b11, 1'b1);
      look_val("stag_val", 32'hA5);
      nxt();
      look("stag_t2", 4'b0000, 2'b10, 1'b1);
      nxt(); rd_ready = 2'b00;
      look("stag_t3", 4'b0000, 2'b10, 1'b1);
      nxt(); rd_ready = 2'b10;
      look("stag_t4", 4'b0000, 2'b10, 1'b1);
      nxt(); rd_ready = 2'b00; wr_valid = '0;
      look("stag_t5", 4'b0000, 2'b00, 1'b0);

      // Same-value write is accepted without a broadcast
      nxt(); set_val(3, 32'h5); wr_valid = 4'b1000; rd_ready = 2'b11;
      look("same_set", 4'b1000, 2'b00, 1'b0);
      nxt(); wr_valid = '0;
      look("same_bc", 4'b0000, 2'b11, 1'b1);
      look_val("same_val5", 32'h5);
      nxt(); set_val(1, 32'h5); set_val(2, 32'h77); wr_valid = 4'b0110;
      look("same_w1", 4'b0010, 2'b00, 1'b0);
      nxt();
      look("same_next", 4'b0100, 2'b00, 1'b0);
      look_val("same_keep", 32'h5);
      nxt(); wr_valid = '0;
      look("same_bc2", 4'b0000, 2'b11, 1'b1);
      look_val("same_val77", 32'h77);

      // Both readers ack together: pending writer granted in the first IDLE cycle
      nxt(); set_val(0, 32'h99); wr_valid = 4'b0001;
      look("both_grant", 4'b0001, 2'b00, 1'b0);
      nxt(); wr_valid = 4'b1000;
      look("both_t1", 4'b0000, 2'b11, 1'b1);
      nxt();
      look("both_t2", 4'b1000, 2'b00, 1'b0);
      nxt(); wr_valid = '0;
      look("both_t3", 4'b0000, 2'b11, 1'b1);
      look_val("both_val", 32'h5);

      // Reset mid-broadcast with only reader 0 still pending
      nxt(); set_val(1, 32'h3C); wr_valid = 4'b0010; rd_ready = 2'b00;
      look("rbc_grant", 4'b0010, 2'b00, 1'b0);
      nxt(); wr_valid = '0; rd_ready = 2'b10;
      look("rbc_t1", 4'b0000, 2'b11, 1'b1);
      nxt(); rd_ready = 2'b00;
      look("rbc_t2", 4'b0000, 2'b01, 1'b1);
      #2; wr_valid = 4'hF; core_rst = 1'b1;
      look("rbc_rst", 4'b0000, 2'b00, 1'b0);
      look_val("rbc_val", 32'h0);
      nxt(); core_rst = 1'b0; rd_ready = 2'b11;
      look("rbc_first", 4'b0001, 2'b00, 1'b0);
      nxt(); wr_valid = '0;
      look("rbc_bc", 4'b0000, 2'b11, 1'b1);
      look_val("rbc_val99", 32'h99);

      // Lone writer 3: grant every 2 cycles, then last_grant wraps 3 -> 0
      for (int i = 0; i < 3; i++) begin
         nxt(); set_val(3, 32'h100 + i); wr_valid = 4'b1000;
         look($sformatf("w3_grant%0d", i), 4'b1000, 2'b00, 1'b0);
         nxt();
         look($sformatf("w3_bc%0d", i), 4'b0000, 2'b11, 1'b1);
         look_val($sformatf("w3_val%0d", i), 32'h100 + i);
      end
      nxt(); wr_valid = 4'b0011;
      look("wrap_grant", 4'b0001, 2'b00, 1'b0);
      nxt(); wr_valid = '0;
      look("wrap_bc", 4'b0000, 2'b11, 1'b1);
      look_val("wrap_val", 32'h99);
      nxt();
      look("end_idle", 4'b0000, 2'b00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
